// File: rtl/ab_input_conditioner.sv
// Conditions two raw asynchronous inputs into clean, synchronous A/B levels
// (2-flop sync + consecutive-sample debounce + post-reset warm-up gate).
// Optional build macro AB_PULSE_OUT_EN turns A/B into single-cycle rising-edge pulses.
module ab_input_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic A,
  output logic B,
  output logic valid
);

  // One extra bit so DB_CYCLES+2 never overflows at the top of the legal range.
  localparam int WU_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [WU_W-1:0]  WU_DONE  = WU_W'(DB_CYCLES + 2);

  logic             a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic             b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic             lvl_a_q, lvl_a_d, lvl_b_q, lvl_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [WU_W-1:0]  wu_q, wu_d;
  logic             valid_q, valid_d;
  logic             a_out_q, a_out_d, b_out_q, b_out_d;
`ifdef AB_PULSE_OUT_EN
  logic             lvl_a_prev_q, lvl_a_prev_d, lvl_b_prev_q, lvl_b_prev_d;
`endif

  always_comb begin
    a_s1_d  = a_raw;
    a_s2_d  = a_s1_q;
    b_s1_d  = b_raw;
    b_s2_d  = b_s1_q;
    lvl_a_d = lvl_a_q;
    lvl_b_d = lvl_b_q;
    cnt_a_d = '0;
    cnt_b_d = '0;

    // A mismatch must persist for DB_CYCLES samples; any match clears the count.
    if (a_s2_q != lvl_a_q) begin
      if (cnt_a_q == CNT_LAST) lvl_a_d = a_s2_q;
      else                     cnt_a_d = cnt_a_q + 1'b1;
    end
    if (b_s2_q != lvl_b_q) begin
      if (cnt_b_q == CNT_LAST) lvl_b_d = b_s2_q;
      else                     cnt_b_d = cnt_b_q + 1'b1;
    end

    wu_d    = (wu_q == WU_DONE) ? wu_q : wu_q + 1'b1;
    valid_d = (wu_d == WU_DONE);

`ifdef AB_PULSE_OUT_EN
    lvl_a_prev_d = lvl_a_q;
    lvl_b_prev_d = lvl_b_q;
    a_out_d      = valid_q & lvl_a_q & ~lvl_a_prev_q;
    b_out_d      = valid_q & lvl_b_q & ~lvl_b_prev_q;
`else
    a_out_d      = valid_d & lvl_a_d;
    b_out_d      = valid_d & lvl_b_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_s1_q       <= 1'b0;
      a_s2_q       <= 1'b0;
      b_s1_q       <= 1'b0;
      b_s2_q       <= 1'b0;
      lvl_a_q      <= 1'b0;
      lvl_b_q      <= 1'b0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      wu_q         <= '0;
      valid_q      <= 1'b0;
      a_out_q      <= 1'b0;
      b_out_q      <= 1'b0;
`ifdef AB_PULSE_OUT_EN
      lvl_a_prev_q <= 1'b0;
      lvl_b_prev_q <= 1'b0;
`endif
    end else begin
      a_s1_q       <= a_s1_d;
      a_s2_q       <= a_s2_d;
      b_s1_q       <= b_s1_d;
      b_s2_q       <= b_s2_d;
      lvl_a_q      <= lvl_a_d;
      lvl_b_q      <= lvl_b_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      wu_q         <= wu_d;
      valid_q      <= valid_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
`ifdef AB_PULSE_OUT_EN
      lvl_a_prev_q <= lvl_a_prev_d;
      lvl_b_prev_q <= lvl_b_prev_d;
`endif
    end
  end

  assign A     = a_out_q;
  assign B     = b_out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_ab_input_conditioner.sv
// Bench for ab_input_conditioner: directed scenarios plus randomized bursts,
// checked every cycle against a window-based reference of the conditioning rules.
module tb_ab_input_conditioner;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic A, B, valid;

  int errors = 0;
  int checks = 0;

  ab_input_conditioner #(.DB_CYCLES(DB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
    .A(A), .B(B), .valid(valid)
  );

  always #5 clk = ~clk;

  // Reference: an output level flips once the last DB synchronised samples
  // (raw delayed by two edges) all disagree with it.
  bit m_r1 [2];
  bit m_r2 [2];
  bit m_hist [2][DB];
  int m_fill [2];
  bit m_lvl [2];
  bit m_prev [2];
  bit m_pulse [2];
  int m_edges;
  bit m_valid;

  task automatic model_edge(input bit r, input bit ra, input bit rb);
    bit raw_v [2];
    bit old_valid, s2u, all_diff;
    raw_v[0] = ra;
    raw_v[1] = rb;
    if (!r) begin
      for (int c = 0; c < 2; c++) begin
        m_r1[c] = 0; m_r2[c] = 0; m_fill[c] = 0;
        m_lvl[c] = 0; m_prev[c] = 0; m_pulse[c] = 0;
        for (int k = 0; k < DB; k++) m_hist[c][k] = 0;
      end
      m_edges = 0;
      m_valid = 0;
    end else begin
      old_valid = m_valid;
      for (int c = 0; c < 2; c++) begin
        m_pulse[c] = old_valid & m_lvl[c] & ~m_prev[c];
        m_prev[c]  = m_lvl[c];
        s2u = m_r2[c];
        m_r2[c] = m_r1[c];
        m_r1[c] = raw_v[c];
        for (int k = 0; k < DB - 1; k++) m_hist[c][k] = m_hist[c][k+1];
        m_hist[c][DB-1] = s2u;
        if (m_fill[c] < DB) m_fill[c]++;
        all_diff = (m_fill[c] == DB);
        for (int k = 0; k < DB; k++) if (m_hist[c][k] == m_lvl[c]) all_diff = 0;
        if (all_diff) m_lvl[c] = ~m_lvl[c];
      end
      if (m_edges < DB + 2) m_edges++;
      m_valid = (m_edges == DB + 2);
    end
  endtask

  function automatic bit exp_out(input int c);
`ifdef AB_PULSE_OUT_EN
    return m_pulse[c];
`else
    return m_valid & m_lvl[c];
`endif
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, let the rising edge sample, compare 1 ns later.
  task automatic tick(input bit r, input bit ra, input bit rb);
    @(negedge clk);
    rst = r; a_raw = ra; b_raw = rb;
    @(posedge clk);
    model_edge(r, ra, rb);
    #1;
    check("model_A", A, exp_out(0));
    check("model_B", B, exp_out(1));
    check("model_valid", valid, m_valid);
  endtask

  task automatic ticks(input int n, input bit r, input bit ra, input bit rb);
    for (int i = 0; i < n; i++) tick(r, ra, rb);
  endtask

  initial begin
    int pulses;
    bit ra, rb;
    int len;
    bit bounce [10];
    bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

    // Reset / warm-up with both inputs high
    ticks(3, 0, 1, 1);
    check("reset_A", A, 1'b0);
    check("reset_B", B, 1'b0);
    check("reset_valid", valid, 1'b0);
    ticks(5, 1, 1, 1);
    check("warmup_valid_edge5", valid, 1'b0);
    tick(1, 1, 1);
    check("warmup_valid_edge6", valid, 1'b1);
`ifndef AB_PULSE_OUT_EN
    check("warmup_A_edge6", A, 1'b1);
    check("warmup_B_edge6", B, 1'b1);
`endif

    // Clean rising edge on A only
    ticks(10, 1, 0, 0);
    ticks(5, 1, 1, 0);
    check("clean_A_edge5", A, 1'b0);
    tick(1, 1, 0);
`ifndef AB_PULSE_OUT_EN
    check("clean_A_edge6", A, 1'b1);
`endif
    check("clean_B_low", B, 1'b0);

`ifdef AB_PULSE_OUT_EN
    // Held input gives exactly one pulse, on edge DB+3; falling gives none
    ticks(10, 1, 0, 0);
    ticks(6, 1, 1, 0);
    check("pulse_A_edge6", A, 1'b0);
    tick(1, 1, 0);
    check("pulse_A_edge7", A, 1'b1);
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      tick(1, 1, 0);
      if (A === 1'b1) pulses++;
    end
    for (int i = 0; i < 20; i++) begin
      tick(1, 0, 0);
      if (A === 1'b1) pulses++;
    end
    checks++;
    assert (pulses == 0) else begin
      errors++;
      $error("FAIL pulse_extra observed=%0d expected=0", pulses);
    end
`endif

    // Glitches shorter than DB samples, back to back, never pass
    ticks(10, 1, 0, 0);
    ticks(3, 1, 1, 0);
    tick(1, 0, 0);
    ticks(3, 1, 1, 0);
    ticks(10, 1, 0, 0);
    check("glitch_A_low", A, 1'b0);

    // Bounce then settle high
    for (int i = 0; i < 10; i++) tick(1, bounce[i], 0);
    check("bounce_A_run_edge5", A, 1'b0);
    tick(1, 1, 0);
`ifndef AB_PULSE_OUT_EN
    check("bounce_A_run_edge6", A, 1'b1);
`endif

    // Simultaneous rise on both channels
    ticks(10, 1, 0, 0);
    ticks(5, 1, 1, 1);
    check("simul_A_edge5", A, 1'b0);
    check("simul_B_edge5", B, 1'b0);
    tick(1, 1, 1);
`ifndef AB_PULSE_OUT_EN
    check("simul_A_edge6", A, 1'b1);
    check("simul_B_edge6", B, 1'b1);
`endif

    // Reset while a debounce count is pending
    ticks(10, 1, 0, 0);
    ticks(4, 1, 1, 0);
    tick(0, 1, 0);
    check("midrst_A", A, 1'b0);
    check("midrst_valid", valid, 1'b0);
    ticks(5, 1, 1, 0);
    check("midrst_A_edge5", A, 1'b0);
    check("midrst_valid_edge5", valid, 1'b0);
    tick(1, 1, 0);
    check("midrst_valid_edge6", valid, 1'b1);
`ifndef AB_PULSE_OUT_EN
    check("midrst_A_edge6", A, 1'b1);
`endif

    // Randomized runs of varying length with occasional resets
    for (int i = 0; i < 120; i++) begin
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) tick(0, ra, rb);
      ticks(len, 1, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
